// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and helpers for the sync FIFO read-side client
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RESP    = 2'd2,
        BACKOFF = 2'd3
    } rd_state_e;

    localparam int DEFAULT_WIDTH = 16;

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rd_stream_obuf.sv
// rtl/rd_stream_obuf.sv - circular output buffer with push/pop, occupancy and head data
module rd_stream_obuf
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [occ_width(DEPTH)-1:0] occ,
    output logic [WIDTH-1:0]            head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Depth is a power of two, so pointer wrap is the natural PW-bit rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = (occ != '0) ? mem[head] : '0;

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// rtl/sync_fifo_rd_stream.sv - drains the sync FIFO onto a valid/ready stream; stats under SYNC_FIFO_RD_STATS_EN
module sync_fifo_rd_stream
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OBUF_DEPTH = 2,
    parameter int RETRY_GAP  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 fifo_rd_err,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 underflow
`ifdef SYNC_FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    localparam int OW = occ_width(OBUF_DEPTH);
    localparam int BW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    rd_state_e     state;
    rd_state_e     state_nxt;
    logic [BW-1:0] bo_cnt;
    logic [OW-1:0] occ;
    logic          pop;
    logic          push;
    logic          err_hit;
    logic          room_idle;
    logic          room_resp;

    rd_stream_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign busy    = (state != IDLE) || (occ != '0);

    // RESP looks ahead to the occupancy after this cycle's push and pop.
    assign room_idle = int'(occ) < OBUF_DEPTH;
    assign room_resp = (int'(occ) + 1 - int'(pop)) < OBUF_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (en && room_idle) ? REQ : IDLE;
            REQ:     state_nxt = RESP;
            RESP: begin
                if (fifo_rd_err) begin
                    state_nxt = (RETRY_GAP == 0) ? IDLE : BACKOFF;
                end else begin
                    state_nxt = (en && room_resp) ? REQ : IDLE;
                end
            end
            BACKOFF: state_nxt = (bo_cnt <= BW'(1)) ? IDLE : BACKOFF;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        err_hit = 1'b0;
        if (state == RESP) begin
            push    = ~fifo_rd_err;
            err_hit = fifo_rd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_en <= 1'b0;
            underflow  <= 1'b0;
            bo_cnt     <= '0;
        end else begin
            fifo_rd_en <= (state_nxt == REQ);
            underflow  <= err_hit;
            if (err_hit) begin
                bo_cnt <= BW'(RETRY_GAP);
            end else if (state == BACKOFF) begin
                bo_cnt <= bo_cnt - BW'(1);
            end
        end
    end

`ifdef SYNC_FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            if (push && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            if (err_hit && (err_count != '1)) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
